// File: rtl/sp_stack_if.sv
// Bundles the command and status signals of the stack register file.
//   master : drives clear/push/pop/push_data, observes the status outputs
//   slave  : the stack itself
interface sp_stack_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SP_W   = 5
);
    logic              clear;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic [SP_W:0]     sp;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output clear, push, pop, push_data,
        input  pop_data, pop_valid, sp, full, empty, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, push_data,
        output pop_data, pop_valid, sp, full, empty, overflow, underflow
    );
endinterface

// File: rtl/sp_stack_mem.sv
// LIFO register file at the storage end of the stack-pointer datapath.
// Ports:
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   bus (slave)     : clear/push/pop/push_data commands in; registered
//                     pop_data/pop_valid/sp/overflow/underflow and
//                     combinational full/empty decodes out
module sp_stack_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SP_W   = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    sp_stack_if.slave    bus
);
    localparam int unsigned DEPTH = 2 ** SP_W;
    localparam int unsigned CNT_W = SP_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  sp_q, sp_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              we;
    logic [SP_W-1:0]   waddr;
    logic [SP_W-1:0]   top_idx;
    logic              full_c;
    logic              empty_c;

    // Status decodes of the occupancy count
    assign full_c  = (sp_q == CNT_W'(DEPTH));
    assign empty_c = (sp_q == '0);
    // Only meaningful when not empty
    assign top_idx = SP_W'(sp_q - CNT_W'(1));

    // Command decode: next state and write strobe
    always_comb begin
        sp_d        = sp_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        we          = 1'b0;
        waddr       = sp_q[SP_W-1:0];

        if (bus.clear) begin
            sp_d        = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            unique case ({bus.push, bus.pop})
                2'b10: begin
                    if (full_c) begin
                        overflow_d = 1'b1;
                    end else begin
                        we   = 1'b1;
                        sp_d = sp_q + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (empty_c) begin
                        underflow_d = 1'b1;
                    end else begin
                        pop_data_d  = mem[top_idx];
                        pop_valid_d = 1'b1;
                        sp_d        = sp_q - CNT_W'(1);
                    end
                end
                2'b11: begin
                    we = 1'b1;
                    if (empty_c) begin
                        // Illegal pop is flagged, but the push still lands in slot 0
                        underflow_d = 1'b1;
                        waddr       = '0;
                        sp_d        = CNT_W'(1);
                    end else begin
                        // Replace top: read old value, overwrite in place
                        pop_data_d  = mem[top_idx];
                        pop_valid_d = 1'b1;
                        waddr       = top_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q        <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= bus.push_data;
        end
    end

    assign bus.sp        = sp_q;
    assign bus.pop_data  = pop_data_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;
endmodule

// File: tb/tb_sp_stack_mem.sv
// Randomized self-checking bench for sp_stack_mem against a queue-based model.
module tb_sp_stack_mem;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SP_W   = 5;
    localparam int unsigned DEPTH  = 32;

    logic clk;
    logic rst_n;

    sp_stack_if #(.DATA_W(DATA_W), .SP_W(SP_W)) bus ();

    sp_stack_mem #(.DATA_W(DATA_W), .SP_W(SP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the stack is a queue, back = top of stack
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_pd;
    bit                m_pv;
    bit                m_ovf;
    bit                m_unf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pd  = '0;
        m_pv  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_apply(input bit c, input bit ps, input bit pp, input logic [DATA_W-1:0] d);
        m_pv = 1'b0;
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (ps && pp) begin
            if (mq.size() == 0) begin
                m_unf = 1'b1;
                mq.push_back(d);
            end else begin
                m_pd = mq[mq.size()-1];
                m_pv = 1'b1;
                mq[mq.size()-1] = d;
            end
        end else if (ps) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else                    mq.push_back(d);
        end else if (pp) begin
            if (mq.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                m_pd = mq.pop_back();
                m_pv = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sp"},        64'(bus.sp),        64'(mq.size()));
        chk({tag, ".full"},      64'(bus.full),      64'(mq.size() == DEPTH));
        chk({tag, ".empty"},     64'(bus.empty),     64'(mq.size() == 0));
        chk({tag, ".overflow"},  64'(bus.overflow),  64'(m_ovf));
        chk({tag, ".underflow"}, 64'(bus.underflow), 64'(m_unf));
        chk({tag, ".pop_valid"}, 64'(bus.pop_valid), 64'(m_pv));
        chk({tag, ".pop_data"},  64'(bus.pop_data),  64'(m_pd));
    endtask

    // One clock: drive, clock, then compare #1 after the edge
    task automatic step(input string tag, input bit c, input bit ps, input bit pp,
                        input logic [DATA_W-1:0] d);
        bus.clear     = c;
        bus.push      = ps;
        bus.pop       = pp;
        bus.push_data = d;
        @(posedge clk);
        #1;
        model_apply(c, ps, pp, d);
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        bit fill_bias;
        rst_n         = 1'b0;
        bus.clear     = 1'b0;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.push_data = '0;
        model_reset();
        #22;
        check_all("reset");
        rst_n = 1'b1;

        // Three pushes then three pops
        step("p11", 0, 1, 0, 32'h11);
        step("p22", 0, 1, 0, 32'h22);
        step("p33", 0, 1, 0, 32'h33);
        for (int i = 0; i < 3; i++) step("pop3", 0, 0, 1, '0);
        step("idle", 0, 0, 0, '0);

        // Fill, overflow, replace-top while full
        for (int i = 0; i < 32; i++) step("fill", 0, 1, 0, 32'(i));
        step("ovf", 0, 1, 0, 32'hFF);
        step("repl_full", 0, 1, 1, 32'hAA);
        step("pop_aa", 0, 0, 1, '0);
        step("repl_back", 0, 1, 0, 32'hAB);

        // Drain to sp=4, then clear with a concurrent push
        for (int i = 0; i < 28; i++) step("drain", 0, 0, 1, '0);
        chk("sp_before_clear", 64'(bus.sp), 64'd4);
        step("clear_push", 1, 1, 0, 32'hDEAD);

        // Underflow cases
        step("unf_pop", 0, 0, 1, '0);
        step("unf_pushpop", 0, 1, 1, 32'h5);
        step("pop_5", 0, 0, 1, '0);
        step("clr", 1, 0, 0, '0);

        // Pop immediately after push, then alternation
        step("p7", 0, 1, 0, 32'h7);
        step("pop7", 0, 0, 1, '0);
        for (int i = 0; i < 8; i++) begin
            step("alt_push", 0, 1, 0, $urandom);
            step("alt_pop", 0, 0, 1, '0);
        end

        // Asynchronous reset right after a pop edge
        step("pre_rst_push", 0, 1, 0, 32'h99);
        step("pre_rst_pop", 0, 0, 1, '0);
        bus.pop = 1'b0;
        rst_n   = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #3;
        rst_n = 1'b1;
        step("post_rst", 0, 0, 0, '0);

        // Randomized traffic with alternating fill/drain bias
        fill_bias = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) fill_bias = ~fill_bias;
            r = int'($urandom_range(0, 99));
            if (r < 2)
                step("rnd_clr", 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            else if (r < 12)
                step("rnd_pp", 0, 1, 1, $urandom);
            else if (r < 17)
                step("rnd_idle", 0, 0, 0, $urandom);
            else if ((r < 75) == fill_bias)
                step("rnd_push", 0, 1, 0, $urandom);
            else
                step("rnd_pop", 0, 0, 1, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
